ram_block_reader: RTL and testbench
===================================

Name: ram_block_reader

Overview:
- Sequential read engine for the 16-bit-address, 32-bit-data RAM; the read-side counterpart to the RAM write path.
- On a start command, reads a contiguous block of COUNT words from BASE and streams each word out over a valid/ready interface.
- Keeps a running XOR checksum of all delivered words.
- Sits between the RAM and any consumer (CPU loader, debug dump, memory self-check).

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 32, RAM data width.
- RD_LAT, 1, clock edges after the address is presented at which ram_d_out is valid to sample; 1 = asynchronous-read RAM, 2 = registered RAM; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on start.
- count  in  16  number of words to read; latched on start.
- abort  in  1  synchronous cancel of the current block.
- busy  out  1  high from the edge that accepts start until the return to IDLE.
- done  out  1  one-cycle pulse when the last word has been handed off.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  word read from RAM.
- out_addr  out  ADDR_W  address out_data was read from.
- checksum  out  DATA_W  XOR of all words handed off in the current block; cleared on start.
- ram_enable  out  1  RAM enable.
- ram_read_write  out  1  1 = read, 0 = write; this block only ever drives 1 while ram_enable is high.
- ram_address  out  ADDR_W  RAM address.
- ram_d_in  out  DATA_W  RAM write data; always driven 0.
- ram_d_out  in  DATA_W  RAM read data.

Behaviour:
- Reset: state = IDLE. busy, done, out_valid, ram_enable and ram_read_write are 0. out_data, out_addr, checksum and ram_address are 0.
- IDLE:
  - When start=1, latch base_addr into cur_addr and count into remaining, and clear checksum.
  - count=0: go to DONE. No RAM access occurs.
  - Otherwise go to ISSUE. busy rises on the same edge.
- ISSUE:
  - Drive ram_enable=1, ram_read_write=1 and ram_address=cur_addr, all held stable for RD_LAT cycles (down-counter).
  - On the RD_LAT-th edge, capture ram_d_out into out_data and cur_addr into out_addr, set out_valid=1, and go to HOLD.
- HOLD:
  - ram_enable=0. out_data and out_addr are held stable while out_ready=0.
  - On an edge with out_valid and out_ready both high:
    - out_valid goes to 0.
    - checksum ^= out_data.
    - cur_addr increments, wrapping 0xFFFF to 0x0000 with no error.
    - remaining decrements.
    - remaining was 1: go to DONE. Otherwise go to ISSUE.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy falls on the edge leaving DONE.
- Latency and throughput:
  - First out_valid rises RD_LAT edges after the start-accepting edge.
  - With out_ready tied high, throughput is one word per RD_LAT+1 cycles.
- start outside IDLE is ignored.
- count=0 behaviour: done pulses on the edge after start, busy is high for exactly that one cycle, and checksum stays 0.
- abort (any non-IDLE state):
  - Next state is IDLE. out_valid, ram_enable and busy drop on that edge.
  - done does not pulse. checksum keeps its partial value.
- abort and start asserted together in IDLE: start wins.
- A word is handed off in HOLD on the same edge abort is seen: abort wins; the word is not counted in checksum.
- rst asserted mid-block overrides everything and returns all outputs to reset values on the next edge.

Decomposition:
- Shared package (mem_pkg):
  - ADDR_W and DATA_W constants.
  - RAM_READ=1'b1 and RAM_WRITE=1'b0 constants, shared with the RAM and the write-side driver.
  - State enum {IDLE, ISSUE, HOLD, DONE}.
- One natural sub-module, rd_out_stage: the out_data/out_addr/out_valid holding register with valid/ready handoff and checksum update. The FSM and address/count logic stay in the top module.

Test Plan:
RAM preload for all tests: addr 0..7 = 0000AAAA, 000000AA, 000000BB, 000000CC, 000000DD, 000000EE, 000000FF, 0000FFFF.
- Basic block read: base=0, count=8, out_ready=1, RD_LAT=1 -> 8 words appear in address order; each word's first out_valid cycle is 2 cycles after the previous one; single done pulse; checksum = 0000AAAA ^ 000000AA ^ 000000BB ^ 000000CC ^ 000000DD ^ 000000EE ^ 000000FF ^ 0000FFFF; ram_read_write=1 whenever ram_enable=1; ram_d_in=0 throughout.
- Backpressure: base=2, count=3, out_ready low for 5 cycles at each word -> out_data stays 000000BB while stalled; ram_enable=0 during stall; sequence BB, CC, DD; done after the third handshake.
- Wrap and zero count: base=FFFF, count=2 -> out_addr FFFF then 0000, second word 0000AAAA. Separately, count=0 -> done on the next cycle, ram_enable never asserted, checksum=0.
- Abort mid-block: base=0, count=8, abort in the cycle after the third handshake -> IDLE next edge, out_valid=0, no done pulse, checksum = 0000AAAA ^ 000000AA ^ 000000BB.
- Registered RAM: RD_LAT=2 -> address held 2 cycles per word; same data and checksum as the basic block read.
- Reset mid-read: rst asserted during HOLD -> all outputs 0 next edge; a new start afterwards completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared RAM widths, access-direction encoding and reader FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic RAM_READ  = 1'b1;
    localparam logic RAM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/ram_block_reader_rd_out_stage.sv
`default_nettype none
// ============================================================================
// Module  : rd_out_stage
// Brief   : Output holding register with valid/ready handoff and XOR checksum.
// Revision: 1.0 - initial release
// ============================================================================
module rd_out_stage #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              flush,
    input  logic              clear_sum,
    input  logic [DATA_W-1:0] cap_data,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] checksum,
    output logic              handoff
);
    import mem_pkg::*;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] sum_q,   sum_d;

    // A cancel on the handoff edge suppresses the handoff entirely.
    assign handoff = valid_q & out_ready & ~flush;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        if (clear_sum) begin
            sum_d = '0;
        end
        if (handoff) begin
            valid_d = 1'b0;
            sum_d   = sum_q ^ data_q;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            valid_d = 1'b1;
            data_d  = cap_data;
            addr_d  = cap_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign checksum  = sum_q;

endmodule : rd_out_stage
`default_nettype wire

// File: rtl/ram_block_reader.sv
`default_nettype none
// ============================================================================
// Module  : ram_block_reader
// Brief   : Reads COUNT contiguous RAM words from BASE and streams them out.
// Revision: 1.0 - initial release
// ============================================================================
module ram_block_reader #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] checksum,
    output logic              ram_enable,
    output logic              ram_read_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_d_in,
    input  logic [DATA_W-1:0] ram_d_out
);
    import mem_pkg::*;

    localparam int                LAT_W    = 2;
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(RD_LAT - 1);

    state_t            state_q,       state_d;
    logic [ADDR_W-1:0] cur_addr_q,    cur_addr_d;
    logic [CNT_W-1:0]  remaining_q,   remaining_d;
    logic [LAT_W-1:0]  lat_cnt_q,     lat_cnt_d;
    logic              busy_q,        busy_d;
    logic              done_q,        done_d;
    logic              ram_enable_q,  ram_enable_d;
    logic              ram_rw_q,      ram_rw_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;

    logic              capture;
    logic              clear_sum;
    logic              handoff;
    logic              abort_act;
    logic [ADDR_W-1:0] next_addr;

    assign abort_act = abort & (state_q != IDLE);
    assign next_addr = cur_addr_q + ADDR_W'(1);

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        lat_cnt_d     = lat_cnt_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        ram_enable_d  = ram_enable_q;
        ram_rw_d      = ram_rw_q;
        ram_address_d = ram_address_q;
        capture       = 1'b0;
        clear_sum     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d  = base_addr;
                    remaining_d = count;
                    clear_sum   = 1'b1;
                    busy_d      = 1'b1;
                    if (count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = ISSUE;
                        ram_enable_d  = 1'b1;
                        ram_rw_d      = RAM_READ;
                        ram_address_d = base_addr;
                        lat_cnt_d     = LAT_INIT;
                    end
                end
            end
            ISSUE: begin
                // Address is held until the RD_LAT-th edge, where data is sampled.
                if (lat_cnt_q == '0) begin
                    capture      = 1'b1;
                    state_d      = HOLD;
                    ram_enable_d = 1'b0;
                    ram_rw_d     = RAM_WRITE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            HOLD: begin
                if (handoff) begin
                    cur_addr_d  = next_addr;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = ISSUE;
                        ram_enable_d  = 1'b1;
                        ram_rw_d      = RAM_READ;
                        ram_address_d = next_addr;
                        lat_cnt_d     = LAT_INIT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_act) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            ram_enable_d = 1'b0;
            ram_rw_d     = RAM_WRITE;
            capture      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            lat_cnt_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ram_enable_q  <= 1'b0;
            ram_rw_q      <= RAM_WRITE;
            ram_address_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            lat_cnt_q     <= lat_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ram_enable_q  <= ram_enable_d;
            ram_rw_q      <= ram_rw_d;
            ram_address_q <= ram_address_d;
        end
    end

    rd_out_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .flush     (abort_act),
        .clear_sum (clear_sum),
        .cap_data  (ram_d_out),
        .cap_addr  (cur_addr_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .checksum  (checksum),
        .handoff   (handoff)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign ram_enable     = ram_enable_q;
    assign ram_read_write = ram_rw_q;
    assign ram_address    = ram_address_q;
    assign ram_d_in       = '0;

endmodule : ram_block_reader
`default_nettype wire

// File: tb/tb_ram_block_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_block_reader
// Brief   : Scoreboard bench for ram_block_reader with async (RD_LAT=1) and
//           registered (RD_LAT=2) RAM models driven from shared stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_block_reader;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } exp_t;

    localparam logic [31:0] SUM8 = 32'h0000AAAA ^ 32'h000000AA ^ 32'h000000BB ^ 32'h000000CC
                                 ^ 32'h000000DD ^ 32'h000000EE ^ 32'h000000FF ^ 32'h0000FFFF;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready, sel;
    logic [15:0] base_addr, count;

    logic        busy1, done1, ov1, ren1, rrw1;
    logic [31:0] od1, cs1, rdin1, rdo1;
    logic [15:0] oa1, ra1;
    logic        busy2, done2, ov2, ren2, rrw2;
    logic [31:0] od2, cs2, rdin2, rdo2;
    logic [15:0] oa2, ra2;

    logic        busy, done, ov, ren, rrw;
    logic [31:0] od, cs, rdin;
    logic [15:0] oa, ra;

    logic [31:0] mem [0:65535];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_cnt = 0, en_cnt = 0, hs_cnt = 0, viol = 0;
    int   done_base, en_base, hs_base, start_cyc;
    exp_t sb_q[$];
    int   rise_q[$];
    logic prev_en = 1'b0, prev_ov = 1'b0;
    logic [15:0] prev_ra = '0;

    ram_block_reader #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .abort(abort), .busy(busy1), .done(done1), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_addr(oa1), .checksum(cs1), .ram_enable(ren1),
        .ram_read_write(rrw1), .ram_address(ra1), .ram_d_in(rdin1), .ram_d_out(rdo1)
    );

    ram_block_reader #(.RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .abort(abort), .busy(busy2), .done(done2), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2), .out_addr(oa2), .checksum(cs2), .ram_enable(ren2),
        .ram_read_write(rrw2), .ram_address(ra2), .ram_d_in(rdin2), .ram_d_out(rdo2)
    );

    // Async-read RAM for the RD_LAT=1 instance, registered RAM for RD_LAT=2.
    assign rdo1 = mem[ra1];
    always @(posedge clk) if (ren2) rdo2 <= mem[ra2];

    assign busy = sel ? busy2 : busy1;
    assign done = sel ? done2 : done1;
    assign ov   = sel ? ov2   : ov1;
    assign ren  = sel ? ren2  : ren1;
    assign rrw  = sel ? rrw2  : rrw1;
    assign od   = sel ? od2   : od1;
    assign cs   = sel ? cs2   : cs1;
    assign rdin = sel ? rdin2 : rdin1;
    assign oa   = sel ? oa2   : oa1;
    assign ra   = sel ? ra2   : ra1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (ren) begin
            en_cnt++;
            if (rrw !== 1'b1) viol++;
            if (prev_en && ra !== prev_ra) viol++;
        end
        if (rdin !== 32'h0) viol++;
        if (ov && !prev_ov) rise_q.push_back(cyc);
        if (ov && out_ready && !abort) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_word", {16'h0, oa, od}, 64'h0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_addr", oa, e.a);
                chk("sb_data", od, e.d);
            end
        end
        prev_en = ren;
        prev_ra = ra;
        prev_ov = ov;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic start_block(input logic [15:0] b, input logic [15:0] n, input int push_n);
        exp_t e;
        for (int i = 0; i < push_n; i++) begin
            e.a = b + 16'(i);
            e.d = mem[e.a];
            sb_q.push_back(e);
        end
        base_addr = b; count = n; start = 1'b1;
        rise_q.delete();
        done_base = done_cnt; en_base = en_cnt; hs_base = hs_cnt;
        tick();
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin tick(); n++; end
        chk("wait_idle", busy, 1'b0);
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!ov && n < limit) begin tick(); n++; end
        chk("wait_valid", ov, 1'b1);
    endtask

    task automatic run_basic(input int lat);
        out_ready = 1'b1;
        start_block(16'h0000, 16'd8, 8);
        wait_idle(200);
        chk("basic_sb_empty", sb_q.size(), 0);
        chk("basic_done_pulses", done_cnt - done_base, 1);
        chk("basic_checksum", cs, SUM8);
        chk("basic_en_cycles", en_cnt - en_base, 8 * lat);
        chk("basic_rise_count", rise_q.size(), 8);
        for (int i = 0; i < rise_q.size() && i < 8; i++) begin
            if (i == 0) chk("basic_first_latency", rise_q[0], start_cyc + lat);
            else        chk("basic_word_gap", rise_q[i] - rise_q[i-1], lat + 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; sel = 1'b0;
        base_addr = '0; count = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[0] = 32'h0000AAAA; mem[1] = 32'h000000AA; mem[2] = 32'h000000BB; mem[3] = 32'h000000CC;
        mem[4] = 32'h000000DD; mem[5] = 32'h000000EE; mem[6] = 32'h000000FF; mem[7] = 32'h0000FFFF;
        mem[16'hFFFF] = 32'h12345678;

        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_valid", ov, 1'b0);
        chk("rst_ram_enable", ren, 1'b0);
        chk("rst_ram_rw", rrw, 1'b0);
        chk("rst_out_data", od, 32'h0);
        chk("rst_out_addr", oa, 16'h0);
        chk("rst_checksum", cs, 32'h0);
        chk("rst_ram_address", ra, 16'h0);

        run_basic(1);

        // Backpressure: five stalled cycles per word.
        out_ready = 1'b0;
        start_block(16'h0002, 16'd3, 3);
        for (int w = 0; w < 3; w++) begin
            wait_valid(20);
            repeat (5) begin
                chk("bp_hold_data", od, mem[2 + w]);
                chk("bp_ram_idle", ren, 1'b0);
                tick();
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("bp_done_after_last", done, 1'b1);
        wait_idle(20);
        chk("bp_sb_empty", sb_q.size(), 0);
        chk("bp_checksum", cs, 32'h000000BB ^ 32'h000000CC ^ 32'h000000DD);

        // Address wrap.
        out_ready = 1'b1;
        start_block(16'hFFFF, 16'd2, 2);
        wait_idle(50);
        chk("wrap_sb_empty", sb_q.size(), 0);
        chk("wrap_checksum", cs, 32'h12345678 ^ 32'h0000AAAA);
        chk("wrap_done_pulses", done_cnt - done_base, 1);

        // Zero count.
        start_block(16'h0005, 16'd0, 0);
        chk("zero_done_high", done, 1'b1);
        chk("zero_busy_high", busy, 1'b1);
        chk("zero_checksum", cs, 32'h0);
        tick();
        chk("zero_done_low", done, 1'b0);
        chk("zero_busy_low", busy, 1'b0);
        chk("zero_no_ram_access", en_cnt - en_base, 0);
        chk("zero_done_pulses", done_cnt - done_base, 1);

        // Abort in the cycle after the third handshake.
        begin
            int n = 0;
            out_ready = 1'b1;
            start_block(16'h0000, 16'd8, 3);
            while ((hs_cnt - hs_base) < 3 && n < 100) begin tick(); n++; end
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_busy", busy, 1'b0);
            chk("abort_out_valid", ov, 1'b0);
            chk("abort_ram_enable", ren, 1'b0);
            tick(); tick(); tick();
            chk("abort_handshakes", hs_cnt - hs_base, 3);
            chk("abort_no_done", done_cnt - done_base, 0);
            chk("abort_checksum", cs, 32'h0000AAAA ^ 32'h000000AA ^ 32'h000000BB);
            chk("abort_sb_empty", sb_q.size(), 0);
        end

        // Registered RAM instance.
        sel = 1'b1;
        do_reset();
        run_basic(2);

        // Reset while holding a word.
        out_ready = 1'b0;
        start_block(16'h0000, 16'd8, 0);
        wait_valid(20);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_out_valid", ov, 1'b0);
        chk("mid_rst_out_data", od, 32'h0);
        chk("mid_rst_checksum", cs, 32'h0);
        chk("mid_rst_ram_enable", ren, 1'b0);
        chk("mid_rst_ram_address", ra, 16'h0);
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        start_block(16'h0000, 16'd3, 3);
        wait_idle(50);
        chk("post_rst_sb_empty", sb_q.size(), 0);
        chk("post_rst_checksum", cs, 32'h0000AAAA ^ 32'h000000AA ^ 32'h000000BB);
        chk("post_rst_done_pulses", done_cnt - done_base, 1);

        chk("ram_protocol_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule : tb_ram_block_reader
`default_nettype wire
